// File: rtl/fp8_pkg.sv
// FP8 (1-4-3, bias 7) add front end: shared widths, classes and bundles.
package fp8_pkg;

  localparam int EXP_W    = 4;
  localparam int MAN_W    = 3;
  localparam int SIG_W    = 4;
  localparam int GRS_W    = 3;
  localparam int EXP_BIAS = 7;
  localparam int EXP_MAX  = 15;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    INF  = 2'b01,
    NAN  = 2'b10
  } special_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
    logic             is_inf;
    logic             is_nan;
  } unpacked_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] big_sig;
    logic [SIG_W-1:0] small_sig;
    logic [EXP_W-1:0] shift;
    logic             sub;
    logic             swapped;
    special_e         special;
    logic             special_sign;
  } s1_t;

  typedef struct packed {
    logic                   sign;
    logic [EXP_W-1:0]       exp;
    logic [SIG_W-1:0]       big_sig;
    logic [SIG_W+GRS_W-1:0] small_sig;
    logic                   sub;
    logic                   swapped;
    special_e               special;
    logic                   special_sign;
  } s2_t;

endpackage

// File: rtl/fp8_unpack.sv
// Combinational FP8 field split: hidden bit, effective exponent,
// infinity/NaN flags.
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [7:0] op,
  output unpacked_t  u
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             e_max;

  assign e     = op[6:3];
  assign m     = op[2:0];
  assign e_max = (e == EXP_W'(EXP_MAX));

  always_comb begin
    u         = '0;
    u.sign    = op[7];
    // subnormals share the exponent of the smallest normal
    u.eff_exp = (e == '0) ? EXP_W'(1) : e;
    u.sig     = {e != '0, m};
    u.is_inf  = e_max && (m == '0);
    u.is_nan  = e_max && (m != '0);
  end

endmodule

// File: rtl/fp8_add_align.sv
// FP8 add alignment: 2-stage valid/ready pipeline producing the larger
// significand and the shifted smaller one with guard/round/sticky.
module fp8_add_align
  import fp8_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_exp,
  output logic [SIG_W-1:0]       out_big_sig,
  output logic [SIG_W+GRS_W-1:0] out_small_sig,
  output logic                   out_sub,
  output logic                   out_swapped,
  output logic [1:0]             out_special,
  output logic                   out_special_sign
);

  localparam int EXT_W = SIG_W + 14;

  unpacked_t ua, ub, big, sml;
  s1_t       s1_d, s1_q;
  s2_t       s2_d, s2_q;
  logic      s1_valid, s2_valid;
  logic      s1_load, s2_load;
  logic      a_big, nan_c, inf_c;
  logic [EXT_W-1:0] ext;

  fp8_unpack u_unpack_a (.op(in_a), .u(ua));
  fp8_unpack u_unpack_b (.op(in_b), .u(ub));

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // magnitude order of the raw encoding equals numeric order
  assign a_big = (in_a[6:0] >= in_b[6:0]);
  assign big   = a_big ? ua : ub;
  assign sml   = a_big ? ub : ua;

  assign nan_c = ua.is_nan || ub.is_nan ||
                 (ua.is_inf && ub.is_inf && (ua.sign ^ ub.sign));
  assign inf_c = !nan_c && (ua.is_inf || ub.is_inf);

  always_comb begin
    s1_d           = '0;
    s1_d.sign      = big.sign;
    s1_d.exp       = big.eff_exp;
    s1_d.big_sig   = big.sig;
    s1_d.small_sig = sml.sig;
    s1_d.shift     = big.eff_exp - sml.eff_exp;
    s1_d.sub       = ua.sign ^ ub.sign;
    s1_d.swapped   = !a_big;
    unique case (1'b1)
      nan_c: begin
        s1_d.special      = NAN;
        s1_d.special_sign = 1'b0;
      end
      inf_c: begin
        s1_d.special      = INF;
        s1_d.special_sign = ua.is_inf ? ua.sign : ub.sign;
      end
      default: begin
        s1_d.special      = NONE;
        s1_d.special_sign = 1'b0;
      end
    endcase
  end

  // bits below position 12 of the extension all fold into sticky
  assign ext = {s1_q.small_sig, 14'b0} >> s1_q.shift;

  always_comb begin
    s2_d              = '0;
    s2_d.sign         = s1_q.sign;
    s2_d.exp          = s1_q.exp;
    s2_d.big_sig      = s1_q.big_sig;
    s2_d.small_sig    = {ext[EXT_W-1 -: SIG_W], ext[13], ext[12],
                         |ext[11:0]};
    s2_d.sub          = s1_q.sub;
    s2_d.swapped      = s1_q.swapped;
    s2_d.special      = s1_q.special;
    s2_d.special_sign = s1_q.special_sign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid        = s2_valid;
  assign out_sign         = s2_q.sign;
  assign out_exp          = s2_q.exp;
  assign out_big_sig      = s2_q.big_sig;
  assign out_small_sig    = s2_q.small_sig;
  assign out_sub          = s2_q.sub;
  assign out_swapped      = s2_q.swapped;
  assign out_special      = s2_q.special;
  assign out_special_sign = s2_q.special_sign;

endmodule

// File: tb/tb_fp8_add_align.sv
// Bench for fp8_add_align: directed vectors, back-pressure, reset,
// and random traffic against an arithmetic reference model.
module tb_fp8_add_align;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sign;
  logic [3:0] out_exp;
  logic [3:0] out_big_sig;
  logic [6:0] out_small_sig;
  logic       out_sub;
  logic       out_swapped;
  logic [1:0] out_special;
  logic       out_special_sign;

  logic [20:0] dut_vec;
  logic [20:0] q[$];
  logic [20:0] held;
  bit          stall_prev = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  fp8_add_align dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp),
    .out_big_sig(out_big_sig), .out_small_sig(out_small_sig),
    .out_sub(out_sub), .out_swapped(out_swapped),
    .out_special(out_special), .out_special_sign(out_special_sign)
  );

  assign dut_vec = {out_sign, out_exp, out_big_sig, out_small_sig,
                    out_sub, out_swapped, out_special, out_special_sign};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [7:0] x);
    return (x[6:3] == 4'd15) && (x[2:0] != 3'd0);
  endfunction

  function automatic bit is_inf(input logic [7:0] x);
    return (x[6:3] == 4'd15) && (x[2:0] == 3'd0);
  endfunction

  // value-level model: significand as an integer, shift by division
  function automatic logic [20:0] ref_model(input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] bg, sm;
    int be, se, bs, ss, d, kept, lost, g, r, s, sp, sgn;
    bit a_big;
    a_big = int'(a[6:0]) >= int'(b[6:0]);
    bg = a_big ? a : b;
    sm = a_big ? b : a;
    be = (bg[6:3] == 0) ? 1 : int'(bg[6:3]);
    se = (sm[6:3] == 0) ? 1 : int'(sm[6:3]);
    bs = ((bg[6:3] != 0) ? 8 : 0) + int'(bg[2:0]);
    ss = ((sm[6:3] != 0) ? 8 : 0) + int'(sm[2:0]);
    d = be - se;
    kept = ss / (1 << d);
    lost = ss % (1 << d);
    g = (d >= 1) ? (lost / (1 << (d - 1))) % 2 : 0;
    r = (d >= 2) ? (lost / (1 << (d - 2))) % 2 : 0;
    s = (d >= 3) ? int'((lost % (1 << (d - 2))) != 0) : 0;
    sp = 0;
    sgn = 0;
    if (is_nan(a) || is_nan(b) ||
        (is_inf(a) && is_inf(b) && (a[7] != b[7]))) begin
      sp = 2;
    end else if (is_inf(a) || is_inf(b)) begin
      sp = 1;
      sgn = is_inf(a) ? int'(a[7]) : int'(b[7]);
    end
    return {bg[7], 4'(be), 4'(bs), 4'(kept), 1'(g), 1'(r), 1'(s),
            a[7] ^ b[7], !a_big, 2'(sp), 1'(sgn)};
  endfunction

  // scoreboard: sampled on the falling edge, away from state changes
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(dut_vec), 32'(held));
      end
      chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (out_valid && out_ready) begin
        chk("out_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk("out_data", 32'(dut_vec), 32'(q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      held = dut_vec;
      if (in_valid && in_ready) q.push_back(ref_model(in_a, in_b));
    end
  end

  task automatic directed(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [20:0] exp);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(dut_vec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    bit acc;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(dut_vec), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    directed("d_3830", 8'h38, 8'h30,
             {1'b0, 4'd7, 4'b1000, 7'b0100000, 1'b0, 1'b0, 2'b00, 1'b0});
    directed("d_0170", 8'h01, 8'h70,
             {1'b0, 4'd14, 4'b1000, 7'b0000001, 1'b0, 1'b1, 2'b00, 1'b0});
    directed("d_78f8", 8'h78, 8'hF8,
             {1'b0, 4'd15, 4'b1000, 7'b1000000, 1'b1, 1'b0, 2'b10, 1'b0});
    directed("d_7938", 8'h79, 8'h38,
             {1'b0, 4'd15, 4'b1001, 7'b0000001, 1'b0, 1'b0, 2'b10, 1'b0});
    directed("d_f838", 8'hF8, 8'h38,
             {1'b1, 4'd15, 4'b1000, 7'b0000001, 1'b1, 1'b0, 2'b01, 1'b1});
    directed("d_38b8", 8'h38, 8'hB8,
             {1'b0, 4'd7, 4'b1000, 7'b1000000, 1'b1, 1'b0, 2'b00, 1'b0});

    // back-pressure: six pairs, out_ready low on cycles 3..7
    sent = 0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    for (int c = 0; c < 20; c++) begin
      in_valid = (sent < 6);
      out_ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
    end
    chk("bp_sent", 32'(sent), 32'd6);
    drain();

    // reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10 && q.size() < 2; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("mid_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(dut_vec), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    directed("d_post_rst", 8'h38, 8'h30,
             {1'b0, 4'd7, 4'b1000, 7'b0100000, 1'b0, 1'b0, 2'b00, 1'b0});

    // random traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp8_add_align.md
FP8_ADD_ALIGN -- requirements
Module: fp8_add_align

Interface
REQ-001 The block SHALL have ports: clk  input  1  clock; all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  operand pair present.
REQ-004 in_ready  output  1  block accepts pair this cycle.
REQ-005 in_a, in_b  input  8 each  FP8 operands: bit7 sign, bits6:3 exponent, bits2:0 mantissa.
REQ-006 out_valid  output  1  aligned result present.
REQ-007 out_ready  input  1  downstream normalise/round stage accepts.
REQ-008 out_sign  output  1  sign of larger-magnitude operand.
REQ-009 out_exp  output  4  effective exponent of larger operand.
REQ-010 out_big_sig  output  4  larger significand, hidden.mmm.
REQ-011 out_small_sig  output  7  smaller significand after alignment: 4 bits, then guard, round, sticky.
REQ-012 out_sub  output  1  effective subtract (sign_a XOR sign_b).
REQ-013 out_swapped  output  1  in_b was the larger operand.
REQ-014 out_special  output  2  00 none, 01 infinity, 10 NaN.
REQ-015 out_special_sign  output  1  sign of infinity result.

Function
REQ-016 Format SHALL be bias 7. Exp 0 is subnormal: hidden bit 0, effective exponent 1. Exp 1..14 is normal: hidden bit 1. Exp 15 with mantissa 0 is infinity; exp 15 with mantissa not 0 is NaN.
REQ-017 Larger operand SHALL be chosen by unsigned compare of bits6:0; on a tie, in_a is larger and out_swapped=0.
REQ-018 Shift distance SHALL be the difference of effective exponents, range 0..13.
REQ-019 Smaller significand SHALL be shifted right by that distance.
  - First bit shifted out is guard, second is round.
  - OR of all further shifted-out bits is sticky.
  - Distance >=7 yields 0000 00s.
REQ-020 Special cases:
  - Either operand NaN -> out_special=10.
  - Infinity plus opposite-sign infinity -> 10.
  - Otherwise any infinity -> 01, with out_special_sign = sign of the infinity.
REQ-021 Special results SHALL still assert out_valid, with the non-special fields computed per REQ-017..019.
REQ-022 Pipeline SHALL be 2 register stages.
  - S1: unpack, classify, compare, swap, exponent difference.
  - S2: shift, GRS, output registers.
REQ-023 Latency SHALL be 2 cycles from accepted input to out_valid; throughput 1 pair/cycle when out_ready=1.
REQ-024 Transfer SHALL occur only when valid and ready are both 1 on a rising edge.
REQ-025 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Stage advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S2 loads.
  - in_ready = S1 empty or S2 loads, combinational from out_ready.
REQ-027 No pair SHALL be dropped or duplicated under any out_ready pattern; at most 2 pairs in flight.
REQ-028 in_a/in_b SHALL be ignored when in_valid=0.

Reset
REQ-029 rst SHALL immediately clear both stage valid flags and drive out_valid=0 and every out_* data field to 0.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-031 A pair in flight when rst asserts SHALL be discarded; no stale output after release.

Structure
REQ-032 Package fp8_pkg SHALL hold:
  - widths: EXP_W=4, MAN_W=3, SIG_W=4, GRS_W=3
  - EXP_BIAS=7 and EXP_MAX=15
  - special-class enum (NONE, INF, NAN)
  - unpacked-operand struct: sign, eff_exp, sig, is_inf, is_nan
REQ-033 One sub-module, fp8_unpack, SHALL be combinational and instantiated twice, once per operand in S1.

Verification
REQ-034 in_a=0x38, in_b=0x30, out_ready=1 -> 2 cycles later: out_exp=7, big_sig=1000, small_sig=0100_000, sub=0, swapped=0, special=00.
REQ-035 in_a=0x01, in_b=0x70 -> out_swapped=1, out_exp=14, big_sig=1000, small_sig=0000_001.
REQ-036 in_a=0x78, in_b=0xF8 -> special=10. in_a=0x79, in_b=0x38 -> special=10. in_a=0xF8, in_b=0x38 -> special=01, special_sign=1.
REQ-037 in_a=0x38, in_b=0xB8 -> sub=1, swapped=0, small_sig=1000_000.
REQ-038 Back-pressure: stream 6 pairs, out_ready low for cycles 3..7 -> in_ready low while both stages are full; all 6 results emerge in order, unchanged, no duplicates.
REQ-039 Reset mid-operation: assert rst with both stages valid -> out_valid=0 in the same cycle; no output follows until a new pair is accepted after release.
